// File: rtl/mult_arb_pkg.sv
// Shared types for the fp32 multiplier sharing arbiter.
//   FP32_W      : operand / product width
//   TAG_MAX_W   : storage width of a tag-pipe requester index (NUM_REQ <= 16)
//   arb_state_e : enable/drain sequencer states
//   tag_entry_t : one tag-pipe stage, {valid, requester index}
package mult_arb_pkg;

  localparam int FP32_W    = 32;
  localparam int TAG_MAX_W = 4;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of req, searching
// circularly upward from ptr.
// Ports:
//   req       in  NUM_REQ  request vector (already qualified by the caller)
//   ptr       in  TAG_W    lane with highest priority this cycle
//   grant     out NUM_REQ  one-hot grant, zero when req is zero
//   grant_idx out TAG_W    encoded index of the granted lane (0 when none)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = TAG_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fp32_mult_share_arb.sv
// Shares one single-issue, fixed-latency fp32 multiplier among NUM_REQ
// requesters. Owns the issue register, a tag pipe matched to the multiplier
// latency, response routing and an enable/drain sequencer.
// Optional build macro FP32_MULT_ARB_STATS_EN adds stat_ops / stat_stall.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   enable                allow new grants
//   req_valid/req_a/req_b per-lane operands, lane i at [32i+31:32i]
//   req_ready             one-hot grant (combinational)
//   rsp_valid/rsp_data    one-hot result strobe and product (registered)
//   mul_a/mul_b/mul_valid_in   multiplier issue (registered)
//   mul_result/mul_valid_out   multiplier return
//   idle                  HALT with nothing in flight
//   err                   sticky: result/tag misalignment seen
//   stat_ops, stat_stall  (FP32_MULT_ARB_STATS_EN) accept count, stall count
//
// state | meaning
// HALT  | no grants, nothing in flight, idle=1
// RUN   | grants allowed while enable=1
// DRAIN | enable dropped, waiting for in-flight products to return
module fp32_mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 1,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FP32_W-1:0] req_a,
  input  logic [NUM_REQ*FP32_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [FP32_W-1:0]         rsp_data,
  output logic [FP32_W-1:0]         mul_a,
  output logic [FP32_W-1:0]         mul_b,
  output logic                      mul_valid_in,
  input  logic [FP32_W-1:0]         mul_result,
  input  logic                      mul_valid_out,
  output logic                      idle,
  output logic                      err
`ifdef FP32_MULT_ARB_STATS_EN
  ,
  output logic [31:0]               stat_ops,
  output logic [31:0]               stat_stall
`endif
);

  arb_state_e          state_q, state_d;
  logic [TAG_W-1:0]    ptr_q;
  logic [TAG_W-1:0]    grant_idx;
  logic [TAG_W-1:0]    issue_tag;
  logic                grant_en;
  logic                accept;
  logic                pipe_busy;
  logic                pipe_empty;
  tag_entry_t          pipe_q [MUL_LAT];
  tag_entry_t          tail;
  logic [NUM_REQ-1:0]  rsp_onehot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_rr (
    .req       (req_valid & {NUM_REQ{grant_en}}),
    .ptr       (ptr_q),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign accept     = |req_ready;
  assign tail       = pipe_q[MUL_LAT-1];
  assign rsp_onehot = NUM_REQ'(1) << tail.tag;

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) pipe_busy = pipe_busy | pipe_q[i].valid;
  end

  assign pipe_empty = !mul_valid_in && !pipe_busy;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HALT;
    else        state_q <= state_d;
  end

  // FSM: next state; enable wins over the drain-complete exit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALT:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)          state_d = RUN;
        else if (pipe_empty) state_d = HALT;
      end
      default: state_d = HALT;
    endcase
  end

  // FSM: outputs; enable gates the grant combinationally so a request in
  // the cycle enable drops is never accepted
  always_comb begin
    grant_en = (state_q == RUN) && enable;
    idle     = (state_q == HALT) && pipe_empty;
  end

  // Round-robin pointer and issue register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      mul_valid_in <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      issue_tag    <= '0;
    end else begin
      mul_valid_in <= accept;
      if (accept) begin
        ptr_q     <= (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        mul_a     <= req_a[int'(grant_idx)*FP32_W +: FP32_W];
        mul_b     <= req_b[int'(grant_idx)*FP32_W +: FP32_W];
        issue_tag <= grant_idx;
      end
    end
  end

  // Tag pipe shifts in the issue register, so the tail lines up with
  // mul_valid_out MUL_LAT cycles after mul_valid_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: mul_valid_in, tag: TAG_MAX_W'(issue_tag)};
      for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Response routing; a result without a tag or a tag without a result is
  // dropped and latched as an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= (mul_valid_out && tail.valid) ? rsp_onehot : '0;
      if (mul_valid_out && tail.valid) rsp_data <= mul_result;
      if (mul_valid_out != tail.valid) err <= 1'b1;
    end
  end

`ifdef FP32_MULT_ARB_STATS_EN
  // Stall counts cycles where the arbiter may grant, something asks, and
  // nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (accept) stat_ops <= stat_ops + 32'd1;
      if (grant_en && (|req_valid) && !accept) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fp32_mult_share_arb.md
Name: fp32_mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one fp32 multiplier among NUM_REQ requesters, e.g. the wavelet filter tap lanes.
- The multiplier is single-issue, fixed latency, with no backpressure; its valid_in/valid_out pair is driven from this block.
- Owns the issue register, a tag pipeline matched to the multiplier latency, response routing, and an enable/drain state machine.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MUL_LAT, 1, multiplier latency in cycles, from mul_valid_in to mul_valid_out (1..8).
- TAG_W, $clog2(NUM_REQ), width of the requester index tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  allow new grants
- req_valid  in  NUM_REQ  per-requester operand valid
- req_a  in  NUM_REQ*32  operand A, lane i at [32i+31:32i]
- req_b  in  NUM_REQ*32  operand B, same packing as req_a
- req_ready  out  NUM_REQ  one-hot grant, combinational
- rsp_valid  out  NUM_REQ  one-hot result strobe, registered
- rsp_data  out  32  product for the strobed lane, registered
- mul_a  out  32  multiplier operand A, registered
- mul_b  out  32  multiplier operand B, registered
- mul_valid_in  out  1  issue strobe to the multiplier, registered
- mul_result  in  32  multiplier product
- mul_valid_out  in  1  multiplier result strobe
- idle  out  1  high in HALT with no operation in flight
- err  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, active-low): all outputs 0 except idle=1; rr pointer=0; tag pipe cleared; state=HALT. Reset mid-operation discards in-flight results, and no rsp_valid is emitted for them.
- Handshake: a requester holds req_valid and its operands stable until it sees req_valid&req_ready. Accept is req_valid[i]&req_ready[i].
- Response side has no backpressure: requesters must take rsp_data in the strobe cycle.
- Grant:
  - At most one grant per cycle, and only in state RUN.
  - req_ready is the first set bit of req_valid, searching circularly from the rr pointer.
  - After a grant to lane i, pointer=(i+1) mod NUM_REQ. With no grant, the pointer holds.
- Issue: on accept at cycle t, mul_a/mul_b/mul_valid_in are registered at t+1. mul_valid_in=0 in cycles with no accept; mul_a/mul_b hold their last value.
- Tag pipe:
  - Shift register of {valid, tag}, depth MUL_LAT, loaded in step with mul_valid_in.
  - When mul_valid_out=1 and the tail is valid: rsp_valid=onehot(tail tag) and rsp_data=mul_result, registered.
  - Accept-to-rsp latency is exactly MUL_LAT+2 cycles.
  - Throughput is one product per cycle.
- Error conditions (err set, sticky until reset):
  - mul_valid_out=1 with the tail invalid: no rsp is emitted.
  - Tail valid with mul_valid_out=0: the tag is dropped.
- FSM:
  - HALT → RUN when enable=1.
  - RUN → DRAIN when enable=0.
  - DRAIN → RUN when enable=1.
  - DRAIN → HALT when the tag pipe and issue register are empty.
  - idle=1 only in HALT.
  - enable dropping in the same cycle as a request: no grant that cycle; the transition is evaluated on the registered state, so the grant is blocked combinationally by enable=0.
- Lanes are independent: a lane with a back-to-back request gets at most one grant per NUM_REQ cycles when all lanes request.

Optional Feature:
- FP32_MULT_ARB_STATS_EN defined:
  - Adds output stat_ops (32 bits), counting accepts and wrapping at 2^32.
  - Adds output stat_stall (32 bits), counting cycles in RUN with req_valid≠0 and no grant, which must be 0 under correct operation.
  - Both counters clear on reset.
- Undefined: both ports and counters are absent, with no other change.

Decomposition:
- Package mult_arb_pkg holds:
  - the FP32_W=32 constant;
  - the state enum HALT/RUN/DRAIN;
  - the tag-pipe entry struct {valid, tag}.
- Sub-module rr_arbiter (combinational): inputs are the request vector and pointer; outputs are the one-hot grant and the encoded index.

Test Plan:
- Single lane 0: a=0x40000000 (2.0), b=0x40400000 (3.0), enable=1, with a real MUL_LAT=1 multiplier attached → rsp_valid=0001 and rsp_data=0x40C00000 (6.0) exactly 3 cycles after accept.
- All 4 lanes request continuously, lane i sends a=1.5 (0x3FC00000), b=1.5 → grants cycle through 0,1,2,3,0…; every rsp_data=0x40100000 (2.25); rsp tags follow grant order.
- Drop enable while 1 operation is in flight → no new req_ready; that rsp is still delivered; idle rises after it; a later enable=1 resumes from the stored pointer.
- Assert rst_n=0 one cycle after accept → all outputs 0 and idle=1; no rsp_valid after reset release even when the multiplier emits mul_valid_out.
- Force mul_valid_out=1 with no issue → err=1 and rsp_valid=0; err stays high until reset.
- MUL_LAT=4 with a pipelined model, lanes 1 and 3 alternating → each rsp is routed to the correct lane at latency 6 with no drops.
